cnn_mac_acc_pipe: RTL
=====================

CNN_MAC_ACC_PIPE -- requirements
Module: cnn_mac_acc_pipe

Interface
REQ-001 SHALL have parameter DIN0_WIDTH, default 10: signed multiplicand width.
REQ-002 SHALL have parameter DIN1_WIDTH, default 14: signed multiplier width.
REQ-003 SHALL have parameter ACC_WIDTH, default 32: signed accumulator width; legal range is ACC_WIDTH >= DIN0_WIDTH+DIN1_WIDTH.
REQ-004 SHALL have parameter DOUT_WIDTH, default 16: signed result width.
REQ-005 SHALL have parameter FRAC_SHIFT, default 4: right-shift applied to the accumulator at output; legal range is 0..ACC_WIDTH-1.
REQ-006 SHALL have parameter NUM_STAGE, default 2: multiplier pipeline depth; legal range is >= 1.
REQ-007 SHALL have port ap_clk, input, width 1: sole clock, rising edge.
REQ-008 SHALL have port ap_rst_n, input, width 1: reset, synchronous and active-low.
REQ-009 SHALL have port in_valid, input, width 1: input beat present.
REQ-010 SHALL have port in_ready, output, width 1: block accepts a beat.
REQ-011 SHALL have port in_last, input, width 1: beat closes the current dot-product frame.
REQ-012 SHALL have port din0, input, width DIN0_WIDTH: signed operand a.
REQ-013 SHALL have port din1, input, width DIN1_WIDTH: signed operand b.
REQ-014 SHALL have port out_valid, output, width 1: result present.
REQ-015 SHALL have port out_ready, input, width 1: consumer accepts the result.
REQ-016 SHALL have port dout, output, width DOUT_WIDTH: rounded, saturated frame sum.
REQ-017 SHALL have port out_sat, output, width 1: dout was clipped.

Function
REQ-018 Beat acceptance SHALL occur when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational global stall).
REQ-019 When in_ready=0, every pipeline register (product stages, valid/last tags, accumulator) SHALL hold its value.
REQ-020 Product SHALL be the full-precision signed product (DIN0_WIDTH+DIN1_WIDTH bits), sign-extended to ACC_WIDTH, and delayed NUM_STAGE advancing cycles with valid and last tags.
REQ-021 Accumulator SHALL load the product on the first beat of a frame and add the product on later beats; it SHALL wrap two's-complement on overflow.
REQ-022 The beat following a last beat SHALL start a new frame; back-to-back frames SHALL need no idle cycles.
REQ-023 On the last beat the output register SHALL capture r = (acc + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT (no add when FRAC_SHIFT=0).
REQ-024 r SHALL be saturated to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1], and out_sat SHALL be 1 iff clipping occurred.
REQ-025 With no stall, out_valid SHALL rise NUM_STAGE+1 cycles after the last beat is accepted; throughput SHALL be one beat per cycle.
REQ-026 dout, out_sat and out_valid SHALL be stable while out_valid && !out_ready.
REQ-027 When out_valid && out_ready hold and a new result arrives in the same cycle, the new result SHALL replace the old one, and out_valid SHALL stay 1.
REQ-028 When in_valid=0, a bubble SHALL propagate without altering the accumulator.

Reset
REQ-029 While ap_rst_n=0 at a rising edge, out_valid=0, dout=0, out_sat=0, all valid tags=0 and the accumulator SHALL clear, and the frame state SHALL become "first beat".
REQ-030 Reset mid-frame SHALL discard partial sums; the next accepted beat SHALL start a new frame.
REQ-031 in_ready SHALL be 1 during and after reset.

Structure
REQ-032 The shared package cnn_mac_pkg SHALL hold the default widths and the saturation-limit constant functions.
REQ-033 The multiplier pipeline SHALL be one sub-module, cnn_mac_mul_pipe (signed a*b, NUM_STAGE registers, clock-enable = in_ready), mapped to DSP48.

Verification
REQ-034 The bench SHALL check: one beat with last, a=-3, b=100, defaults -> out_valid 3 cycles later, dout=-19, out_sat=0.
REQ-035 The bench SHALL check: 4 beats a=511, b=8191 -> dout=32767, out_sat=1; 4 beats a=-512, b=8191 -> dout=-32768, out_sat=1.
REQ-036 The bench SHALL check: out_ready=0 for 5 cycles with frames pending -> in_ready=0, dout stable, all results later delivered in order, none lost or duplicated.
REQ-037 The bench SHALL check: ap_rst_n low 1 cycle after 2 of 4 beats, then one beat a=1, b=16 -> dout=1, with no residue from the aborted frame.
REQ-038 The bench SHALL check: continuous single-beat frames, out_ready=1 -> one result per cycle, each dout = round(a*b/16).

Source files
------------

// File: rtl/cnn_mac_pkg.sv
// Shared defaults, tag type and saturation-limit helpers for the CNN MAC datapath.
package cnn_mac_pkg;

  localparam int DEF_DIN0_WIDTH = 10;
  localparam int DEF_DIN1_WIDTH = 14;
  localparam int DEF_ACC_WIDTH  = 32;
  localparam int DEF_DOUT_WIDTH = 16;
  localparam int DEF_FRAC_SHIFT = 4;
  localparam int DEF_NUM_STAGE  = 2;

  // Sideband that travels alongside each product through the pipeline.
  typedef struct packed {
    logic vld;
    logic lst;
  } beat_tag_t;

  // Largest value representable in a signed field of the given width.
  function automatic longint sat_hi(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/cnn_mac_mul_pipe.sv
// Signed multiplier with NUM_STAGE output registers and a shared clock enable,
// shaped so the multiply and its pipeline registers fold into a DSP48 slice.
module cnn_mac_mul_pipe
  import cnn_mac_pkg::*;
#(
  parameter int A_WIDTH   = DEF_DIN0_WIDTH,
  parameter int B_WIDTH   = DEF_DIN1_WIDTH,
  parameter int NUM_STAGE = DEF_NUM_STAGE,
  localparam int P_WIDTH  = A_WIDTH + B_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic                      valid_i,
  input  logic                      last_i,
  input  logic signed [A_WIDTH-1:0] a_i,
  input  logic signed [B_WIDTH-1:0] b_i,
  output logic signed [P_WIDTH-1:0] p_o,
  output logic                      valid_o,
  output logic                      last_o
);

  beat_tag_t                 tag_q  [NUM_STAGE];
  logic signed [P_WIDTH-1:0] prod_q [NUM_STAGE];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        tag_q[i] <= '0;
      end
    end else if (en_i) begin
      tag_q[0] <= '{vld: valid_i, lst: last_i};
      for (int i = 1; i < NUM_STAGE; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // NOTE: the product registers carry no reset; only the valid tags decide
  // whether a stage holds meaningful data, and a resettable data path would
  // keep the registers out of the DSP slice.
  always_ff @(posedge clk) begin
    if (en_i) begin
      prod_q[0] <= P_WIDTH'(a_i) * P_WIDTH'(b_i);
      for (int i = 1; i < NUM_STAGE; i++) begin
        prod_q[i] <= prod_q[i-1];
      end
    end
  end

  assign p_o     = prod_q[NUM_STAGE-1];
  assign valid_o = tag_q[NUM_STAGE-1].vld;
  assign last_o  = tag_q[NUM_STAGE-1].lst;

endmodule

// File: rtl/cnn_mac_acc_pipe.sv
// Streaming dot-product engine: pipelined multiply, frame accumulator, then
// round/shift/saturate into a single output register under a global stall.
module cnn_mac_acc_pipe
  import cnn_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = DEF_DIN0_WIDTH,
  parameter int DIN1_WIDTH = DEF_DIN1_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
  parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
  parameter int NUM_STAGE  = DEF_NUM_STAGE
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         out_sat
);

  localparam int PROD_WIDTH = DIN0_WIDTH + DIN1_WIDTH;
  localparam int RND_BIT    = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
  // Half an output LSB, or nothing when there is no fractional shift.
  localparam logic signed [ACC_WIDTH:0] ROUND_ADD =
    (ACC_WIDTH + 1)'(FRAC_SHIFT > 0) << RND_BIT;
  localparam longint DOUT_MAX = sat_hi(DOUT_WIDTH);
  localparam longint DOUT_MIN = sat_lo(DOUT_WIDTH);

  logic signed [PROD_WIDTH-1:0] mul_p;
  logic                         mul_vld;
  logic                         mul_lst;
  logic signed [ACC_WIDTH-1:0]  prod_ext;

  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                         acc_vld_q;
  logic                         acc_lst_q;
  logic                         first_q, first_d;

  logic signed [ACC_WIDTH:0]    acc_rnd;
  logic signed [ACC_WIDTH:0]    acc_shr;
  longint                       r_wide;
  logic signed [DOUT_WIDTH-1:0] dout_d;
  logic                         sat_d;
  logic                         res_take;

  logic                         out_valid_q;
  logic signed [DOUT_WIDTH-1:0] dout_q;
  logic                         sat_q;

  // A full output register that is not being drained freezes every stage.
  assign in_ready = !out_valid_q || out_ready;

  cnn_mac_mul_pipe #(
    .A_WIDTH   (DIN0_WIDTH),
    .B_WIDTH   (DIN1_WIDTH),
    .NUM_STAGE (NUM_STAGE)
  ) u_mul (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .en_i    (in_ready),
    .valid_i (in_valid),
    .last_i  (in_last),
    .a_i     (din0),
    .b_i     (din1),
    .p_o     (mul_p),
    .valid_o (mul_vld),
    .last_o  (mul_lst)
  );

  assign prod_ext = ACC_WIDTH'(mul_p);

  // NOTE: every signal assigned here gets its default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_d   = acc_q;
    first_d = first_q;
    if (mul_vld) begin
      acc_d   = first_q ? prod_ext : acc_q + prod_ext;
      first_d = mul_lst;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking ones stay in always_comb.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      acc_q     <= '0;
      acc_vld_q <= 1'b0;
      acc_lst_q <= 1'b0;
      first_q   <= 1'b1;
    end else if (in_ready) begin
      acc_q     <= acc_d;
      acc_vld_q <= mul_vld;
      acc_lst_q <= mul_vld && mul_lst;
      first_q   <= first_d;
    end
  end

  // One guard bit keeps the rounding add from wrapping before the shift.
  always_comb begin
    acc_rnd = {acc_q[ACC_WIDTH-1], acc_q} + ROUND_ADD;
    acc_shr = acc_rnd >>> FRAC_SHIFT;
    r_wide  = longint'(acc_shr);
    dout_d  = acc_shr[DOUT_WIDTH-1:0];
    sat_d   = 1'b0;
    if (r_wide > DOUT_MAX) begin
      dout_d = DOUT_MAX[DOUT_WIDTH-1:0];
      sat_d  = 1'b1;
    end else if (r_wide < DOUT_MIN) begin
      dout_d = DOUT_MIN[DOUT_WIDTH-1:0];
      sat_d  = 1'b1;
    end
  end

  assign res_take = acc_vld_q && acc_lst_q;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      sat_q       <= 1'b0;
    end else if (in_ready) begin
      out_valid_q <= res_take;
      if (res_take) begin
        dout_q <= dout_d;
        sat_q  <= sat_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign out_sat   = sat_q;

endmodule
